mem_data_memory: RTL and testbench
==================================

MEM_DATA_MEMORY -- requirements
Module: mem_data_memory

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL expose parameter DEPTH_WORDS, default 256, giving the number of 32-bit memory words.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 mem_write  input  1  store enable, sampled at the rising edge of clk.
REQ-006 mem_read  input  1  load enable, combinational.
REQ-007 load_mode  input  2  load width: 00 word, 01 signed halfword, 10 signed byte, 11 unsigned byte.
REQ-008 address  input  32  byte address from the ALU.
REQ-009 write_data  input  32  store data; a store always writes the full word.
REQ-010 write_back  input  1  register-write control passed into the MEM/WB stage.
REQ-011 read_data  output  32  combinational load result.
REQ-012 wb_write_back  output  1  registered write_back.
REQ-013 wb_read_data  output  32  registered read_data.
REQ-014 wb_address  output  32  registered address, forwarded as the ALU result.

Function
REQ-015 Memory SHALL be byte-addressed and big-endian, with word index address[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap.
REQ-016 Word access SHALL ignore address[1:0], so word accesses are forced to word alignment.
REQ-017 Stores SHALL write write_data to the addressed word at the rising clk edge when mem_write=1; mem_write=0 leaves memory unchanged.
REQ-018 Loads SHALL be combinational; when mem_read=1, read_data depends on load_mode as follows.
- 00: read_data = the whole word.
- 01: read_data = the halfword selected by address[1] (0 = bits 31:16), sign-extended.
- 10: read_data = the byte selected by address[1:0] (0 = bits 31:24), sign-extended.
- 11: read_data = the same byte as mode 10, zero-extended.
REQ-019 When mem_read=0, read_data SHALL be 32'h0.
REQ-020 If a read and a write hit the same word in one cycle, read_data SHALL show the old contents until the edge and the new contents after it.
REQ-021 The block SHALL have a latency of one cycle: on each rising clk edge with rst=0, wb_write_back<=write_back, wb_read_data<=read_data and wb_address<=address.
REQ-022 If mem_read=1 and mem_write=1 together, the block SHALL perform both operations per REQ-020; neither operation has priority.
REQ-023 Memory contents SHALL be zero at time 0 for simulation.

Reset
REQ-024 While rst=1, wb_write_back, wb_read_data and wb_address SHALL be 0 immediately, independent of clk.
REQ-025 Reset SHALL NOT alter memory contents.
REQ-026 A store whose edge coincides with rst=1 SHALL still update memory.
REQ-027 Deasserting reset mid-operation SHALL resume normal pipeline capture at the next rising edge.

Verification
REQ-028 Word store then load:
- write 0x8899AABB to address 0x10, then read with mode 00 at 0x10 -> read_data = 0x8899AABB.
- one edge later -> wb_read_data = 0x8899AABB and wb_address = 0x10.
REQ-029 Halfword and byte loads from word 0x8899AABB at 0x10:
- mode 01 at 0x12 -> 0xFFFFAABB.
- mode 10 at 0x11 -> 0xFFFFFF99.
- mode 11 at 0x13 -> 0x000000BB.
- mode 10 at 0x13 -> 0xFFFFFFBB.
REQ-030 Read disabled: mem_read=0 at 0x10 -> read_data = 0; next edge -> wb_read_data = 0.
REQ-031 Same-cycle read and write: word 0x20 holds 0x11111111; write 0x22222222 to 0x20 with mem_read=1.
- before the edge -> read_data = 0x11111111.
- after the edge -> read_data = 0x22222222.
REQ-032 Wrap and alignment, with DEPTH_WORDS=256:
- write 0xDEADBEEF to 0x400 -> mode 00 read at 0x000 returns 0xDEADBEEF.
- mode 00 read at 0x003 also returns 0xDEADBEEF.
REQ-033 Asynchronous reset: assert rst mid-cycle with write_back=1 registered.
- wb outputs go to 0 before the next edge.
- memory still returns previously stored data.

Source files
------------

// File: rtl/mem_data_memory.sv
// mem_data_memory: byte-addressed big-endian data memory with MEM/WB pipeline register.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset (reset clears only the WB registers)
//   mem_write       - store enable; write_data stored as a full word at the rising edge
//   mem_read        - load enable; read_data is 0 when low
//   load_mode       - 00 word, 01 signed halfword, 10 signed byte, 11 unsigned byte
//   address         - byte address; word index is address[log2(DEPTH_WORDS)+1:2], upper bits wrap
//   write_data      - store data
//   write_back      - register-write control carried into MEM/WB
//   read_data       - combinational load result
//   wb_write_back, wb_read_data, wb_address - MEM/WB registered copies
module mem_data_memory #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  load_mode,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_back,
    output logic [31:0] read_data,
    output logic        wb_write_back,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_address
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [15:0] half;
    logic [7:0]  bsel;
    logic        wb_write_back_d, wb_write_back_q;
    logic [31:0] wb_read_data_d, wb_read_data_q;
    logic [31:0] wb_address_d, wb_address_q;

    assign idx = address[AW+1:2];

    // Memory is outside the reset domain so stores land even while rst is high.
    always_ff @(posedge clk) begin
        if (mem_write) mem[idx] <= write_data;
    end

    // Big-endian lane selection: offset 0 is the most significant byte.
    always_comb begin
        word = mem[idx];
        half = address[1] ? word[15:0] : word[31:16];
        bsel = address[1:0] == 2'd0 ? word[31:24] :
               address[1:0] == 2'd1 ? word[23:16] :
               address[1:0] == 2'd2 ? word[15:8]  : word[7:0];
        read_data = !mem_read          ? 32'h0 :
                    load_mode == 2'b00 ? word :
                    load_mode == 2'b01 ? {{16{half[15]}}, half} :
                    load_mode == 2'b10 ? {{24{bsel[7]}}, bsel} : {24'h0, bsel};
    end

    always_comb begin
        wb_write_back_d = write_back;
        wb_read_data_d  = read_data;
        wb_address_d    = address;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_write_back_q <= 1'b0;
            wb_read_data_q  <= 32'h0;
            wb_address_q    <= 32'h0;
        end else begin
            wb_write_back_q <= wb_write_back_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_address_q    <= wb_address_d;
        end
    end

    assign wb_write_back = wb_write_back_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_address    = wb_address_q;
endmodule

// File: tb/tb_mem_data_memory.sv
// tb_mem_data_memory: directed scoreboard bench for mem_data_memory.
module tb_mem_data_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [1:0]  load_mode = 2'b00;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        write_back = 1'b0;
    logic [31:0] read_data;
    logic        wb_write_back;
    logic [31:0] wb_read_data;
    logic [31:0] wb_address;

    typedef struct {
        logic        wb;
        logic [31:0] rd;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [256];
    int          tests = 0;
    int          fails = 0;

    mem_data_memory #(.DEPTH_WORDS(256)) dut (
        .clk(clk),
        .rst(rst),
        .mem_write(mem_write),
        .mem_read(mem_read),
        .load_mode(load_mode),
        .address(address),
        .write_data(write_data),
        .write_back(write_back),
        .read_data(read_data),
        .wb_write_back(wb_write_back),
        .wb_read_data(wb_read_data),
        .wb_address(wb_address)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] model_load(input logic r, input logic [1:0] m, input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = model[a[9:2]];
        case (a[1:0])
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            default: b = w[7:0];
        endcase
        h = a[1] ? w[15:0] : w[31:16];
        if (!r) return 32'h0;
        case (m)
            2'b00: return w;
            2'b01: return h[15] ? {16'hFFFF, h} : {16'h0000, h};
            2'b10: return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
            default: return {24'h0, b};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag, input logic w, input logic r, input logic [1:0] m,
                         input logic [31:0] a, input logic [31:0] d, input logic wbk);
        exp_t        e;
        logic [31:0] rd;
        @(negedge clk);
        mem_write = w; mem_read = r; load_mode = m; address = a; write_data = d; write_back = wbk;
        #1;
        rd = model_load(r, m, a);
        chk({tag, "/rd"}, read_data, rd);
        sb.push_back('{wbk, rd, a});
        @(posedge clk);
        if (w) model[a[9:2]] = d;
        #1;
        if (sb.size() == 0) begin
            chk({tag, "/sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "/wb_wb"}, {31'h0, wb_write_back}, {31'h0, e.wb});
            chk({tag, "/wb_rd"}, wb_read_data, e.rd);
            chk({tag, "/wb_addr"}, wb_address, e.addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        #2;
        chk("rst/wb_wb", {31'h0, wb_write_back}, 32'h0);
        chk("rst/wb_rd", wb_read_data, 32'h0);
        chk("rst/wb_addr", wb_address, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("init/zero", model_load(1'b1, 2'b00, 32'h10), 32'h0);
        cycle("st10", 1, 0, 2'b00, 32'h10, 32'h8899AABB, 1);
        cycle("ld_w10", 0, 1, 2'b00, 32'h10, 32'h0, 1);
        chk("ld_w10/lit", wb_read_data, 32'h8899AABB);
        cycle("ld_h12", 0, 1, 2'b01, 32'h12, 32'h0, 0);
        chk("ld_h12/lit", wb_read_data, 32'hFFFFAABB);
        cycle("ld_h10", 0, 1, 2'b01, 32'h10, 32'h0, 0);
        cycle("ld_sb11", 0, 1, 2'b10, 32'h11, 32'h0, 1);
        chk("ld_sb11/lit", wb_read_data, 32'hFFFFFF99);
        cycle("ld_ub13", 0, 1, 2'b11, 32'h13, 32'h0, 0);
        chk("ld_ub13/lit", wb_read_data, 32'h000000BB);
        cycle("ld_sb13", 0, 1, 2'b10, 32'h13, 32'h0, 0);
        chk("ld_sb13/lit", wb_read_data, 32'hFFFFFFBB);
        cycle("ld_ub10", 0, 1, 2'b11, 32'h10, 32'h0, 0);
        cycle("ld_sb12", 0, 1, 2'b10, 32'h12, 32'h0, 0);
        cycle("rd_off", 0, 0, 2'b00, 32'h10, 32'h0, 1);
        cycle("st30", 1, 0, 2'b00, 32'h30, 32'h00007F81, 0);
        cycle("ld_h30", 0, 1, 2'b01, 32'h30, 32'h0, 0);
        cycle("ld_h32", 0, 1, 2'b01, 32'h32, 32'h0, 0);
        cycle("ld_sb33", 0, 1, 2'b10, 32'h33, 32'h0, 0);
        cycle("ld_ub33", 0, 1, 2'b11, 32'h33, 32'h0, 0);
        cycle("st20", 1, 0, 2'b00, 32'h20, 32'h11111111, 0);
        cycle("rw20", 1, 1, 2'b00, 32'h20, 32'h22222222, 1);
        chk("rw20/after", read_data, 32'h22222222);
        cycle("st400", 1, 0, 2'b00, 32'h400, 32'hDEADBEEF, 0);
        cycle("ld_w000", 0, 1, 2'b00, 32'h000, 32'h0, 0);
        chk("ld_w000/lit", wb_read_data, 32'hDEADBEEF);
        cycle("ld_w003", 0, 1, 2'b00, 32'h003, 32'h0, 0);
        chk("ld_w003/lit", wb_read_data, 32'hDEADBEEF);
        cycle("st3fc", 1, 0, 2'b00, 32'hFFFF_FFFC, 32'hCAFEF00D, 0);
        cycle("ld_w3fc", 0, 1, 2'b00, 32'h3FE, 32'h0, 1);
        chk("pre_rst/wb_wb", {31'h0, wb_write_back}, 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst/wb_wb", {31'h0, wb_write_back}, 32'h0);
        chk("arst/wb_rd", wb_read_data, 32'h0);
        chk("arst/wb_addr", wb_address, 32'h0);
        @(negedge clk);
        mem_write = 1'b1; mem_read = 1'b1; load_mode = 2'b00; address = 32'h40;
        write_data = 32'h5A5A5A5A; write_back = 1'b1;
        #1;
        chk("rst_ld40/old", read_data, 32'h0);
        @(posedge clk);
        model[16] = 32'h5A5A5A5A;
        #1;
        chk("rst_hold/wb_wb", {31'h0, wb_write_back}, 32'h0);
        chk("rst_hold/wb_addr", wb_address, 32'h0);
        chk("rst_ld40/new", read_data, 32'h5A5A5A5A);
        @(negedge clk);
        mem_write = 1'b0;
        address = 32'h10;
        #1;
        chk("rst_ld10", read_data, 32'h8899AABB);
        rst = 1'b0;
        cycle("post_ld40", 0, 1, 2'b00, 32'h40, 32'h0, 1);
        cycle("post_ld10", 0, 1, 2'b10, 32'h10, 32'h0, 0);
        chk("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
